// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan driver.
//   state_t  - scan phase (BLANK between digits, DRIVE while a digit is lit)
//   HEX_SEG  - active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_OFF / AN_OFF - all cathodes / all anodes off
package seg_pkg;
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to active-low segment decode.
//   nib_i   - 4-bit value to show
//   blank_i - 1 forces all segments off
//   seg_o   - active-low {g,f,e,d,c,b,a}
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    assign seg_o = blank_i ? 7'h7F : HEX_SEG[nib_i];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans a double-buffered 32-bit value onto an 8-digit common-anode display as hex.
//   clk, clr      - clock, asynchronous active-high reset
//   data_in, load - value and capture strobe into the shadow register
//   blank_lz      - blank leading zero digits (digit 0 always shown)
//   dp_mask       - live decimal point enables, bit i for digit i
//   SEG, AN       - registered active-low cathodes (SEG[7]=dp) and anodes
//   frame_done    - one-cycle pulse after each frame boundary
//   pending       - shadow holds a value not yet committed to the display
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2000,
    parameter int CW        = 17
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_done,
    output logic        pending
);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d, disp_q, disp_d;
    logic        pending_q, pending_d, fd_q, fd_d;
    logic [7:0]  seg_q, seg_d, an_q, an_d;
    logic        last, boundary, commit, lz;
    logic [3:0]  nib;
    logic [6:0]  dec_seg;

    hex7seg_decode u_dec (
        .nib_i   (nib),
        .blank_i (lz),
        .seg_o   (dec_seg)
    );

    always_comb begin
        last      = (state_q == BLANK) ? (cnt_q == BL_LAST) : (cnt_q == DR_LAST);
        boundary  = (state_q == DRIVE) && last && (idx_q == 3'd7);
        // a load on the boundary commits directly, bypassing the shadow
        commit    = boundary && (pending_q || load);
        state_d   = last ? ((state_q == BLANK) ? DRIVE : BLANK) : state_q;
        cnt_d     = last ? '0 : cnt_q + 1'b1;
        idx_d     = ((state_q == DRIVE) && last) ? idx_q + 3'd1 : idx_q;
        shadow_d  = load ? data_in : shadow_q;
        disp_d    = commit ? (load ? data_in : shadow_q) : disp_q;
        pending_d = commit ? 1'b0 : (load ? 1'b1 : pending_q);
        fd_d      = boundary;
        nib       = disp_q[{idx_q, 2'b00} +: 4];
        // digit is a leading zero when it and every digit above it are zero
        lz        = blank_lz && (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);
        seg_d     = (state_q == DRIVE) ? {~dp_mask[idx_q], dec_seg} : SEG_OFF;
        an_d      = (state_q == DRIVE) ? ~(8'b1 << idx_q) : AN_OFF;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            fd_q      <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            fd_q      <= fd_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign frame_done = fd_q;
    assign pending    = pending_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and randomized checks of seg_scan_driver against a slot/frame arithmetic model.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  SEG, AN;
    logic        frame_done, pending;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .CW(17)) dut (
        .clk(clk), .clr(clr), .data_in(data_in), .load(load), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .SEG(SEG), .AN(AN), .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk = 0, n_pass = 0;
    int c = 0;
    logic [31:0] m_disp = '0, m_shadow = '0;
    logic        m_pend = 1'b0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
    endtask

    // one clock: compute expected outputs for the cycle at the model's position, advance model, compare
    task automatic step(input logic ld, input logic [31:0] din);
        int ph, dig;
        logic [7:0] e_an, e_seg;
        logic e_fd, lzb;
        load = ld;
        data_in = din;
        ph  = c % 5;
        dig = (c % 40) / 5;
        lzb = blank_lz && dig != 0 && ((m_disp >> (4 * dig)) == 32'd0);
        e_an  = (ph == 0) ? 8'hFF : ~(8'b1 << dig);
        e_seg = (ph == 0) ? 8'hFF : {~dp_mask[dig], lzb ? 7'h7F : tbl[m_disp[4*dig +: 4]]};
        e_fd  = (c % 40) == 39;
        if (e_fd && (m_pend || ld)) begin
            m_disp = ld ? din : m_shadow;
            m_pend = 1'b0;
            if (ld) m_shadow = din;
        end else if (ld) begin
            m_shadow = din;
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        chk8("AN", AN, e_an);
        chk8("SEG", SEG, e_seg);
        chk8("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
        chk8("pending", {7'd0, pending}, {7'd0, m_pend});
        c++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 40 && (c % 40) != pos; i++) step(1'b0, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_AN", AN, 8'hFF);
        chk8("rst_SEG", SEG, 8'hFF);
        chk8("rst_fd", {7'd0, frame_done}, 8'd0);
        chk8("rst_pend", {7'd0, pending}, 8'd0);
        clr = 1'b0;
        idle(45);
        run_to(12);
        step(1'b1, 32'h89ABCDEF);
        idle(70);
        run_to(5);
        step(1'b1, 32'h11111111);
        run_to(20);
        step(1'b1, 32'h22222222);
        idle(60);
        run_to(39);
        step(1'b1, 32'h00000005);
        idle(41);
        blank_lz = 1'b1;
        step(1'b1, 32'h00000A00);
        idle(80);
        step(1'b1, 32'h00000000);
        idle(80);
        blank_lz = 1'b0;
        dp_mask = 8'h04;
        idle(40);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 19) == 0)
                step(1'b1, ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> $urandom_range(4, 28)));
            else
                step(1'b0, 32'd0);
        end
        dp_mask = 8'h04;
        blank_lz = 1'b0;
        step(1'b1, 32'h76543210);
        idle(41);
        run_to(27);
        #2;
        clr = 1'b1;
        #1;
        chk8("clr_AN", AN, 8'hFF);
        chk8("clr_SEG", SEG, 8'hFF);
        chk8("clr_pend", {7'd0, pending}, 8'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        c = 0;
        m_disp = '0;
        m_shadow = '0;
        m_pend = 1'b0;
        idle(85);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
